// File: rtl/path_replayer.sv
// path_replayer
//   Drains the direction stack once the maze solver is finished, reverses the
//   popped moves in a local buffer, then replays them first-move-first on a
//   valid/ready stream while tracking the rat's (x,y) position.
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous active-low reset
//   start       one-cycle pulse, begins drain+replay (ignored unless idle)
//   stk_empty   stack empty flag
//   stk_dout    stack data, valid the cycle after stk_pop
//   stk_pop     pop request to the stack
//   dir_out     current replayed direction (00 R, 01 U, 10 L, 11 D)
//   dir_valid   dir_out valid
//   dir_ready   consumer accepts dir_out
//   x, y        current column / row, wrapping modulo 2^CW
//   move_count  number of moves captured
//   busy        high in every state except IDLE
//   done        one-cycle pulse when replay completes
//
// DEPTH must be a power of two; WIDTH must be at least 2 (the low two bits
// carry the direction code).

module path_replayer #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    parameter int CW    = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     stk_empty,
    input  logic [WIDTH-1:0]         stk_dout,
    output logic                     stk_pop,
    output logic [WIDTH-1:0]         dir_out,
    output logic                     dir_valid,
    input  logic                     dir_ready,
    output logic [CW-1:0]            x,
    output logic [CW-1:0]            y,
    output logic [$clog2(DEPTH):0]   move_count,
    output logic                     busy,
    output logic                     done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    typedef enum logic [2:0] {IDLE, POP, CAPT, EMIT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] path_buf [DEPTH];
    logic [AW-1:0]    rd;
    logic             buf_full;

    // This capture fills the last buffer slot: stop draining even if the
    // stack still claims data, so the buffer can never overflow.
    assign buf_full = (move_count == CNTW'(DEPTH - 1));

    // Replay reads straight out of the buffer; forced to zero outside EMIT
    // so the output is quiet (and zero in reset).
    assign dir_out = (state == EMIT) ? path_buf[rd] : '0;

    // Buffer write, no reset needed: entries are always written before read.
    always_ff @(posedge CLK) begin
        if (state == CAPT && !move_count[AW])
            path_buf[move_count[AW-1:0]] <= stk_dout;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            stk_pop    <= 1'b0;
            dir_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            x          <= '0;
            y          <= '0;
            move_count <= '0;
            rd         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x          <= '0;
                        y          <= '0;
                        move_count <= '0;
                        busy       <= 1'b1;
                        if (stk_empty) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= POP;
                            stk_pop <= 1'b1;
                        end
                    end
                end
                POP: begin
                    stk_pop <= 1'b0;
                    state   <= CAPT;
                end
                CAPT: begin
                    move_count <= move_count + CNTW'(1);
                    // stk_empty now reflects the post-pop stack
                    if (stk_empty || buf_full) begin
                        state     <= EMIT;
                        rd        <= move_count[AW-1:0];  // new count - 1
                        dir_valid <= 1'b1;
                    end else begin
                        state   <= POP;
                        stk_pop <= 1'b1;
                    end
                end
                EMIT: begin
                    if (dir_ready) begin
                        case (dir_out[1:0])
                            2'b00: x <= x + CW'(1);
                            2'b01: y <= y - CW'(1);
                            2'b10: x <= x - CW'(1);
                            default: y <= y + CW'(1);
                        endcase
                        if (rd == '0) begin
                            state     <= DONE;
                            dir_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            rd <= rd - AW'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_replayer.sv
// tb_path_replayer
//   Table-driven and randomized bench for path_replayer. A simple stack model
//   feeds the DUT; the expected replay is the push order, and positions are
//   derived by plain modular arithmetic over the move list.

module tb_path_replayer;

    localparam int WIDTH = 2;
    localparam int DEPTH = 256;
    localparam int CW    = 4;
    localparam int CNTW  = 9;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start = 1'b0;
    logic             stk_empty;
    logic [WIDTH-1:0] stk_dout = '0;
    logic             stk_pop;
    logic [WIDTH-1:0] dir_out;
    logic             dir_valid;
    logic             dir_ready = 1'b0;
    logic [CW-1:0]    x, y;
    logic [CNTW-1:0]  move_count;
    logic             busy, done;

    int checks   = 0;
    int failures = 0;

    path_replayer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK), .RST(RST), .start(start), .stk_empty(stk_empty),
        .stk_dout(stk_dout), .stk_pop(stk_pop), .dir_out(dir_out),
        .dir_valid(dir_valid), .dir_ready(dir_ready), .x(x), .y(y),
        .move_count(move_count), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // ---------------- stack model ----------------
    logic [1:0] stack_mem [DEPTH];
    int         sp = 0;
    assign stk_empty = (sp == 0);

    always @(posedge CLK) begin
        if (stk_pop && sp > 0) begin
            stk_dout = stack_mem[sp-1];
            sp = sp - 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- monitor / reference ----------------
    int         cyc = 0;
    always @(posedge CLK) cyc++;

    logic [1:0] exp_q [$];
    int         mx = 0, my = 0;
    int         acc_cnt = 0, done_cnt = 0, first_valid_cyc = -1, last_done_cyc = -1;
    bit         pos_pend = 0, stalled = 0;
    logic [1:0] stall_dir = '0;

    always @(negedge CLK) begin
        logic [1:0] e;
        if (stk_pop) chk("pop_while_empty", int'(stk_empty), 0);
        if (pos_pend) begin
            chk("pos_x", int'(x), mx);
            chk("pos_y", int'(y), my);
            pos_pend = 0;
        end
        if (stalled) begin
            chk("stall_valid", int'(dir_valid), 1);
            chk("stall_dir", int'(dir_out), int'(stall_dir));
        end
        stalled   = dir_valid && !dir_ready;
        stall_dir = dir_out;
        if (dir_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (dir_valid && dir_ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_move", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("dir_out", int'(dir_out), int'(e));
                case (e)
                    2'd0: mx = (mx + 1) % 16;
                    2'd1: my = (my + 15) % 16;
                    2'd2: mx = (mx + 15) % 16;
                    default: my = (my + 1) % 16;
                endcase
                pos_pend = 1;
            end
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    // ---------------- stimulus ----------------
    logic [1:0] push_list [DEPTH];

    // rmode: 0 ready high, 1 pattern 1,0,0,1,1, 2 random. spam: random
    // start pulses while replay is in progress.
    task automatic run_case(input string nm, input int n, input int rmode,
                            input bit spam, input int ex, input int ey,
                            input int budget);
        int st, pi, k;
        bit pat [5];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
        for (int i = 0; i < n; i++) stack_mem[i] = push_list[i];
        sp = n;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(push_list[i]);
        mx = 0; my = 0; acc_cnt = 0; done_cnt = 0;
        first_valid_cyc = -1; last_done_cyc = -1; pi = 0;
        @(posedge CLK); #1;
        start = 1'b1;
        st = cyc;
        dir_ready = (rmode == 0);
        @(posedge CLK); #1;
        start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            case (rmode)
                0: dir_ready = 1'b1;
                1: begin
                    dir_ready = pat[pi % 5];
                    if (dir_valid) pi++;
                end
                default: dir_ready = 1'($urandom_range(0, 1));
            endcase
            start = spam && dir_valid && ($urandom_range(0, 2) == 0);
            @(posedge CLK); #1;
            k++;
        end
        start = 1'b0;
        dir_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_accepted"}, acc_cnt, n);
        chk({nm, "_move_count"}, int'(move_count), n);
        chk({nm, "_final_x"}, int'(x), ex);
        chk({nm, "_final_y"}, int'(y), ey);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_stack_drained"}, sp, 0);
        if (n > 0) chk({nm, "_first_valid_lat"}, first_valid_cyc - st, 2*n + 1);
        else       chk({nm, "_done_lat"}, last_done_cyc - st, 1);
    endtask

    function automatic void exp_pos(input int n, output int ex, output int ey);
        int r, u, l, d;
        r = 0; u = 0; l = 0; d = 0;
        for (int i = 0; i < n; i++)
            case (push_list[i])
                2'd0: r++;
                2'd1: u++;
                2'd2: l++;
                default: d++;
            endcase
        ex = ((r - l) % 16 + 16) % 16;
        ey = ((d - u) % 16 + 16) % 16;
    endfunction

    typedef struct {
        string          nm;
        int             n;
        logic [3:0][1:0] d;     // d[0] pushed first
        int             rmode;
        bit             spam;
        int             ex;
        int             ey;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int ex, ey, n;

        tbl[0] = '{"empty",   0, {2'd0, 2'd0, 2'd0, 2'd0}, 0, 0, 0,  0};
        tbl[1] = '{"rrd",     3, {2'd0, 2'd3, 2'd0, 2'd0}, 0, 0, 2,  1};
        tbl[2] = '{"rrd_stall",3,{2'd0, 2'd3, 2'd0, 2'd0}, 1, 0, 2,  1};
        tbl[3] = '{"wrap_x",  1, {2'd0, 2'd0, 2'd0, 2'd2}, 0, 0, 15, 0};
        tbl[4] = '{"wrap_y",  1, {2'd0, 2'd0, 2'd0, 2'd1}, 0, 0, 0,  15};
        tbl[5] = '{"ddul",    4, {2'd2, 2'd1, 2'd3, 2'd3}, 2, 0, 15, 1};
        tbl[6] = '{"rrd_spam",3, {2'd0, 2'd3, 2'd0, 2'd0}, 2, 1, 2,  1};

        // reset state
        #2;
        chk("rst_stk_pop",   int'(stk_pop), 0);
        chk("rst_dir_valid", int'(dir_valid), 0);
        chk("rst_dir_out",   int'(dir_out), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_done",      int'(done), 0);
        chk("rst_xy",        int'({x, y}), 0);
        chk("rst_count",     int'(move_count), 0);
        @(posedge CLK); #1;
        RST = 1'b1;

        for (int t = 0; t < 7; t++) begin
            for (int i = 0; i < tbl[t].n; i++) push_list[i] = tbl[t].d[i];
            run_case(tbl[t].nm, tbl[t].n, tbl[t].rmode, tbl[t].spam,
                     tbl[t].ex, tbl[t].ey, 200);
        end

        // reset during CAPT of the third pop of a 5-entry drain
        for (int i = 0; i < 5; i++) stack_mem[i] = 2'(i);
        sp = 5;
        exp_q.delete();
        @(posedge CLK); #1;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("prerst_busy",  int'(busy), 1);
        chk("prerst_count", int'(move_count), 2);
        RST = 1'b0;
        #1;
        chk("midrst_stk_pop",   int'(stk_pop), 0);
        chk("midrst_dir_valid", int'(dir_valid), 0);
        chk("midrst_dir_out",   int'(dir_out), 0);
        chk("midrst_busy",      int'(busy), 0);
        chk("midrst_done",      int'(done), 0);
        chk("midrst_xy",        int'({x, y}), 0);
        chk("midrst_count",     int'(move_count), 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        push_list[0] = 2'd3;
        run_case("after_rst", 1, 0, 0, 0, 1, 200);

        // randomized paths
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) push_list[i] = 2'($urandom_range(0, 3));
            exp_pos(n, ex, ey);
            run_case("rand", n, 2, 1'(r & 1), ex, ey, 400);
        end

        // full stack of DEPTH-1 entries
        for (int i = 0; i < DEPTH - 1; i++) push_list[i] = 2'($urandom_range(0, 3));
        exp_pos(DEPTH - 1, ex, ey);
        run_case("full", DEPTH - 1, 2, 1, ex, ey, 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
